// File: rtl/scrod_ack_conditioner_if.sv
// Bundle of the SCROD ACK conditioner's data/control signals.
// Handshake: there is no valid/ready pair. Every signal is a level. The
// master side drives ACK_RAW, the window/hold-off lengths, CNT_SEL and CNT_CLR.
// The slave samples them on every rising clock edge and drives ACK, ACK_CNT,
// STUCK and DBG_STATE back every cycle.
interface scrod_ack_conditioner_if #(
  parameter int N_SCROD = 12
);
  logic [N_SCROD-1:0]   ACK_RAW;
  logic [3:0]           WINDOW_LEN;
  logic [7:0]           HOLDOFF_LEN;
  logic [3:0]           CNT_SEL;
  logic                 CNT_CLR;
  logic [N_SCROD-1:0]   ACK;
  logic [31:0]          ACK_CNT;
  logic [N_SCROD-1:0]   STUCK;
  // Per-channel FSM state, 2 bits per channel, channel i at [2*i +: 2]
  logic [2*N_SCROD-1:0] DBG_STATE;

  modport master (
    output ACK_RAW, WINDOW_LEN, HOLDOFF_LEN, CNT_SEL, CNT_CLR,
    input  ACK, ACK_CNT, STUCK, DBG_STATE
  );

  modport slave (
    input  ACK_RAW, WINDOW_LEN, HOLDOFF_LEN, CNT_SEL, CNT_CLR,
    output ACK, ACK_CNT, STUCK, DBG_STATE
  );
endinterface

// File: rtl/scrod_ack_conditioner.sv
// SCROD ACK conditioner: synchronizes raw ACK lines and turns each accepted
// rising edge into a fixed-width ACK window for the trigger coincidence logic.
// It also applies a per-channel hold-off, keeps saturating hit counters and
// flags stuck-high lines.
module scrod_ack_conditioner #(
  parameter int N_SCROD      = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int STUCK_CYCLES = 255
) (
  input logic                     CLK_80MHZ,
  input logic                     RESET,
  scrod_ack_conditioner_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WIN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int                RUN_W   = $clog2(STUCK_CYCLES + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(STUCK_CYCLES);

  logic [31:0] cnt_all [N_SCROD];
  logic [31:0] ack_cnt_q;

  genvar i;
  for (i = 0; i < N_SCROD; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_q;
    logic [1:0]             state_q, state_d;
    logic [3:0]             win_q, win_d;
    logic [7:0]             hold_q, hold_d;
    logic [31:0]            cnt_q;
    logic [RUN_W-1:0]       run_q;
    logic                   sync_out;
    logic                   accept;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // Only edges that arrive while idle open a window and get counted
    assign accept   = (state_q == ST_IDLE) && edge_q;

    // Synchronizer chain and registered rising-edge detect. Both reset high,
    // so a line held high through reset does not produce a window.
    always_ff @(posedge CLK_80MHZ) begin
      if (RESET) begin
        sync_q <= '1;
        prev_q <= 1'b1;
        edge_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ACK_RAW[i]};
        prev_q <= sync_out;
        edge_q <= sync_out & ~prev_q;
      end
    end

    // Window / hold-off FSM next-state. Lengths are captured only on entry.
    always_comb begin
      state_d = state_q;
      win_d   = win_q;
      hold_d  = hold_q;
      case (state_q)
        ST_IDLE: begin
          if (edge_q) begin
            state_d = ST_WIN;
            win_d   = (bus.WINDOW_LEN == 4'd0) ? 4'd1 : bus.WINDOW_LEN;
          end
        end
        ST_WIN: begin
          if (win_q <= 4'd1) begin
            if (bus.HOLDOFF_LEN != 8'd0) begin
              state_d = ST_HOLD;
              hold_d  = bus.HOLDOFF_LEN;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            win_d = win_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (hold_q <= 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // FSM state registers
    always_ff @(posedge CLK_80MHZ) begin
      if (RESET) begin
        state_q <= ST_IDLE;
        win_q   <= 4'd0;
        hold_q  <= 8'd0;
      end else begin
        state_q <= state_d;
        win_q   <= win_d;
        hold_q  <= hold_d;
      end
    end

    // Accepted-edge counter: saturates, and a clear beats a same-cycle increment
    always_ff @(posedge CLK_80MHZ) begin
      if (RESET || bus.CNT_CLR) begin
        cnt_q <= 32'd0;
      end else if (accept && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    // Consecutive synced-high run length, saturating at the stuck threshold
    always_ff @(posedge CLK_80MHZ) begin
      if (RESET || !sync_out) begin
        run_q <= '0;
      end else if (run_q < RUN_MAX) begin
        run_q <= run_q + 1'b1;
      end
    end

    assign cnt_all[i]              = cnt_q;
    assign bus.ACK[i]              = (state_q == ST_WIN);
    assign bus.STUCK[i]            = (run_q >= RUN_MAX);
    assign bus.DBG_STATE[2*i +: 2] = state_q;
  end

  // Registered counter readback; out-of-range selects read as zero
  always_ff @(posedge CLK_80MHZ) begin
    if (RESET) begin
      ack_cnt_q <= 32'd0;
    end else if (32'(bus.CNT_SEL) < N_SCROD) begin
      ack_cnt_q <= cnt_all[bus.CNT_SEL];
    end else begin
      ack_cnt_q <= 32'd0;
    end
  end

  assign bus.ACK_CNT = ack_cnt_q;

endmodule
